// File: rtl/cov_pkg.sv
// Shared constants, state encoding and output beat layout for the covariance accumulator.
package cov_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_SAMP = 128;
  localparam int unsigned LOG2_N = 7;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = 2 * DATA_W + LOG2_N;
  localparam int unsigned CNT_W  = LOG2_N + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_SCALE = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] IDX_C00 = 2'd0;
  localparam logic [1:0] IDX_C01 = 2'd1;
  localparam logic [1:0] IDX_C11 = 2'd2;

  typedef struct packed {
    logic [1:0]               idx;
    logic signed [PROD_W-1:0] data;
    logic                     last;
  } cov_beat_t;

endpackage

// File: rtl/cov_accumulator_if.sv
// Downstream covariance-entry stream plus run status toward the whitening stage.
interface cov_if;

  logic                              COV_ready;
  logic signed [cov_pkg::PROD_W-1:0] COV_data;
  logic [1:0]                        COV_idx;
  logic                              COV_valid;
  logic                              COV_last;
  logic                              COV_done;
  logic                              COV_err;

  modport master (
    input  COV_ready,
    output COV_data, COV_idx, COV_valid, COV_last, COV_done, COV_err
  );

  modport slave (
    output COV_ready,
    input  COV_data, COV_idx, COV_valid, COV_last, COV_done, COV_err
  );

endinterface

// File: rtl/cov_mac.sv
// One covariance lane: registered signed product feeding a guard-bit accumulator.
module cov_mac
  import cov_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mul_en,
  input  logic                     i_clr,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (i_mul_en) begin
        r_prod <= w_prod;
      end
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_acc_en) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cov_accumulator.sv
// Covariance datapath: accumulates N_SAMP two-channel products, scales by 1/N_SAMP
// and streams c00, c01, c11 over a valid/ready handshake.
module cov_accumulator
  import cov_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     En_Multi,
  input  logic                     En_add_div,
  input  logic signed [DATA_W-1:0] X0_in,
  input  logic signed [DATA_W-1:0] X1_in,
  cov_if.master                    cov
);

  logic [2:0]               r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic                     r_prod_vld;
  logic                     r_en_d;
  cov_beat_t                r_beat, w_beat_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_err, w_err_nxt;
  logic signed [PROD_W-1:0] r_c01, w_c01_nxt;
  logic signed [PROD_W-1:0] r_c11, w_c11_nxt;

  logic signed [ACC_W-1:0]  w_acc [3];
  logic signed [PROD_W-1:0] w_scaled [3];
  logic                     w_clr;
  logic                     w_acc_en;
  logic                     w_en_rise;

  assign w_en_rise = En_add_div & ~r_en_d;

  cov_mac u_mac_c00 (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_mul_en (En_Multi),
    .i_clr    (w_clr),
    .i_acc_en (w_acc_en),
    .i_a      (X0_in),
    .i_b      (X0_in),
    .o_acc    (w_acc[0])
  );

  cov_mac u_mac_c01 (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_mul_en (En_Multi),
    .i_clr    (w_clr),
    .i_acc_en (w_acc_en),
    .i_a      (X0_in),
    .i_b      (X1_in),
    .o_acc    (w_acc[1])
  );

  cov_mac u_mac_c11 (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_mul_en (En_Multi),
    .i_clr    (w_clr),
    .i_acc_en (w_acc_en),
    .i_a      (X1_in),
    .i_b      (X1_in),
    .o_acc    (w_acc[2])
  );

  // Divide by N_SAMP: arithmetic shift floors toward -inf; guard bits drop out after the shift.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_scaled[k] = PROD_W'(w_acc[k] >>> LOG2_N);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_c01_nxt   = r_c01;
    w_c11_nxt   = r_c11;
    w_clr       = 1'b0;
    w_acc_en    = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_en_rise) begin
          w_clr       = 1'b1;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (r_cnt == CNT_W'(N_SAMP)) begin
          w_state_nxt = ST_SCALE;
        end else if (r_prod_vld) begin
          w_acc_en  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!En_add_div) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCALE: begin
        w_c01_nxt   = w_scaled[1];
        w_c11_nxt   = w_scaled[2];
        w_beat_nxt  = '{idx: IDX_C00, data: w_scaled[0], last: 1'b0};
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (r_valid && cov.COV_ready) begin
          case (r_beat.idx)
            IDX_C00: w_beat_nxt = '{idx: IDX_C01, data: r_c01, last: 1'b0};
            IDX_C01: w_beat_nxt = '{idx: IDX_C11, data: r_c11, last: 1'b1};
            default: begin
              w_beat_nxt  = '0;
              w_valid_nxt = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_prod_vld <= 1'b0;
      r_en_d     <= 1'b0;
      r_beat     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_c01      <= '0;
      r_c11      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prod_vld <= En_Multi;
      r_en_d     <= En_add_div;
      r_beat     <= w_beat_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_c01      <= w_c01_nxt;
      r_c11      <= w_c11_nxt;
    end
  end

  assign cov.COV_data  = r_beat.data;
  assign cov.COV_idx   = r_beat.idx;
  assign cov.COV_last  = r_beat.last;
  assign cov.COV_valid = r_valid;
  assign cov.COV_done  = r_done;
  assign cov.COV_err   = r_err;

endmodule
